// File: rtl/servo_pwm_bank.sv
// Multi-channel hobby-servo PWM generator with a shared frame counter and frame-aligned width updates.
// Optional macro SERVO_SLEW_EN limits each frame's width change to STEP cycles.
module servo_pwm_bank #(
    parameter int NUM_CH    = 4,
    parameter int CW        = 20,
    parameter int PERIOD    = 1000000,
    parameter int MIN_PW    = 50000,
    parameter int MAX_PW    = 100000,
    parameter int CENTER_PW = 75000,
    parameter int STEP      = 1000,
    localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [CHW-1:0]    i_wr_ch,
    input  logic [CW-1:0]     i_wr_pw,
    output logic              o_wr_err,
    output logic [NUM_CH-1:0] o_pwm_out,
    output logic              o_frame_start,
    output logic [NUM_CH-1:0] o_busy
);

    localparam logic [CW-1:0]  LP_LAST   = CW'(PERIOD - 1);
    localparam logic [CW-1:0]  LP_MIN    = CW'(MIN_PW);
    localparam logic [CW-1:0]  LP_MAX    = CW'(MAX_PW);
    localparam logic [CW-1:0]  LP_CENTER = CW'(CENTER_PW);
    localparam logic [CHW:0]   LP_NCH    = (CHW + 1)'(NUM_CH);
`ifdef SERVO_SLEW_EN
    localparam logic [CW-1:0]  LP_STEP   = CW'(STEP);
`endif

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("servo_pwm_bank: NUM_CH must be in 1..16");
    end
    if (MAX_PW >= PERIOD) begin : g_bad_max_pw
        $error("servo_pwm_bank: MAX_PW must be less than PERIOD");
    end
    if (MIN_PW > CENTER_PW || CENTER_PW > MAX_PW) begin : g_bad_center
        $error("servo_pwm_bank: need MIN_PW <= CENTER_PW <= MAX_PW");
    end
    if (longint'(PERIOD) > (longint'(1) << CW) || STEP < 1) begin : g_bad_width
        $error("servo_pwm_bank: PERIOD must fit in CW bits and STEP must be positive");
    end

    logic [CW-1:0]     r_cnt;
    logic              r_frame_start;
    logic              r_wr_err;
    logic [NUM_CH-1:0] r_pwm;
    logic [NUM_CH-1:0] r_busy;
    logic [NUM_CH-1:0] r_en_tgt;
    logic [NUM_CH-1:0] r_en_act;
    logic [CW-1:0]     r_target [NUM_CH];
    logic [CW-1:0]     r_active [NUM_CH];

    logic              w_accept;
    logic              w_bad_ch;
    logic              w_frame_end;
    logic [CW-1:0]     w_pw_clamped;
    logic [CW-1:0]     w_next_act [NUM_CH];

    assign o_wr_ready    = ~rst;
    assign w_accept      = i_wr_valid && o_wr_ready;
    assign w_bad_ch      = {1'b0, i_wr_ch} >= LP_NCH;
    assign w_frame_end   = (r_cnt == LP_LAST);
    assign w_pw_clamped  = (i_wr_pw < LP_MIN) ? LP_MIN :
                           (i_wr_pw > LP_MAX) ? LP_MAX : i_wr_pw;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_next_act[i] = r_target[i];
`ifdef SERVO_SLEW_EN
            if (r_target[i] > r_active[i] && (r_target[i] - r_active[i]) > LP_STEP) begin
                w_next_act[i] = r_active[i] + LP_STEP;
            end else if (r_active[i] > r_target[i] && (r_active[i] - r_target[i]) > LP_STEP) begin
                w_next_act[i] = r_active[i] - LP_STEP;
            end
`endif
        end
    end

    // A write landing on the frame-end cycle updates target only; the load below sees the old target.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_frame_start <= 1'b0;
            r_wr_err      <= 1'b0;
            r_pwm         <= '0;
            r_busy        <= '0;
            r_en_tgt      <= '0;
            r_en_act      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_target[i] <= LP_CENTER;
                r_active[i] <= LP_CENTER;
            end
        end else begin
            r_cnt         <= w_frame_end ? '0 : r_cnt + CW'(1);
            r_frame_start <= (r_cnt == '0);
            r_wr_err      <= w_accept && w_bad_ch;
            for (int i = 0; i < NUM_CH; i++) begin
                r_pwm[i]  <= r_en_act[i] && (r_cnt < r_active[i]);
                r_busy[i] <= (r_active[i] != r_target[i]) || (r_en_act[i] != r_en_tgt[i]);
                if (w_frame_end) begin
                    r_active[i] <= w_next_act[i];
                    r_en_act[i] <= r_en_tgt[i];
                end
            end
            if (w_accept && !w_bad_ch) begin
                if (i_wr_pw == '0) begin
                    r_en_tgt[i_wr_ch] <= 1'b0;
                end else begin
                    r_en_tgt[i_wr_ch] <= 1'b1;
                    r_target[i_wr_ch] <= w_pw_clamped;
                end
            end
        end
    end

    assign o_wr_err      = r_wr_err;
    assign o_pwm_out     = r_pwm;
    assign o_frame_start = r_frame_start;
    assign o_busy        = r_busy;

endmodule
